// File: rtl/ddr4_cmd_decoder_if.sv
// Command/address pin bundle and decoded-output bundle for the emulated DIMM
// command decoder.
//   master : host side, drives cke/cs_n/act_n/A/bg/ba and observes the decode
//   slave  : decoder side, samples the pins and drives cmd_*, bank_open,
//            rd_en/wr_en, burst_*, err/err_code
interface ddr4_cmd_decoder_if #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int BL        = 8
);
    localparam int BKWIDTH   = BGWIDTH + BAWIDTH;
    localparam int NBANK     = 1 << BKWIDTH;
    localparam int BEATWIDTH = (BL > 2) ? $clog2(BL / 2) : 1;

    logic                 cke;
    logic                 cs_n;
    logic                 act_n;
    logic [ADDRWIDTH-1:0] A;
    logic [BGWIDTH-1:0]   bg;
    logic [BAWIDTH-1:0]   ba;

    logic                 cmd_valid;
    logic [2:0]           cmd;
    logic [BKWIDTH-1:0]   cmd_bank;
    logic [ADDRWIDTH-1:0] cmd_row;
    logic [COLWIDTH-1:0]  cmd_col;
    logic [NBANK-1:0]     bank_open;
    logic                 rd_en;
    logic                 wr_en;
    logic [BKWIDTH-1:0]   burst_bank;
    logic [ADDRWIDTH-1:0] burst_row;
    logic [COLWIDTH-1:0]  burst_col;
    logic [BEATWIDTH-1:0] burst_beat;
    logic                 err;
    logic [2:0]           err_code;

    modport master (
        output cke, cs_n, act_n, A, bg, ba,
        input  cmd_valid, cmd, cmd_bank, cmd_row, cmd_col, bank_open,
               rd_en, wr_en, burst_bank, burst_row, burst_col, burst_beat,
               err, err_code
    );

    modport slave (
        input  cke, cs_n, act_n, A, bg, ba,
        output cmd_valid, cmd, cmd_bank, cmd_row, cmd_col, bank_open,
               rd_en, wr_en, burst_bank, burst_row, burst_col, burst_beat,
               err, err_code
    );
endinterface

// File: rtl/ddr4_cmd_decoder.sv
// Device-side DDR4 command decoder for the emulated DIMM.
// Samples the command/address pins on every rising ck_t, decodes them into
// typed commands, tracks per-bank open state and open row, schedules read and
// write burst windows at CL / CWL, and flags host protocol violations.
//
// Ports:
//   ck_t     in  : clock, all logic on the rising edge
//   reset_n  in  : synchronous active-low reset
//   bus      slave modport of ddr4_cmd_decoder_if (pins in, decode out)
//
// Optional feature macro: TRCD_CHECK_EN
//   defined   -> per-bank ACT-to-RD/WR spacing check, err code 3
//   undefined -> no tRCD counters, code 3 never produced
//
// err_code: 1 RD/WR to closed bank, 2 ACT to open bank, 3 tRCD, 4 tCCD,
//           5 read/write window overlap, 6 RFU encoding or REF with open bank
module ddr4_cmd_decoder #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int BL        = 8,
    parameter int CL        = 15,
    parameter int CWL       = 11,
    parameter int TRCD      = 15
) (
    input  logic              ck_t,
    input  logic              reset_n,
    ddr4_cmd_decoder_if.slave bus
);
    localparam int BKWIDTH   = BGWIDTH + BAWIDTH;
    localparam int NBANK     = 1 << BKWIDTH;
    localparam int BEATWIDTH = (BL > 2) ? $clog2(BL / 2) : 1;
    localparam logic [BEATWIDTH-1:0] BEAT_LAST = BEATWIDTH'(BL / 2 - 1);

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_PREA = 3'd5,
        CMD_REF  = 3'd6,
        CMD_MRS  = 3'd7
    } cmd_e;

    typedef struct packed {
        logic [BKWIDTH-1:0]   bank;
        logic [ADDRWIDTH-1:0] row;
        logic [COLWIDTH-1:0]  col;
    } burst_t;

    logic                 dec_valid;
    logic                 dec_rfu;
    cmd_e                 dec_cmd;
    logic [BKWIDTH-1:0]   bank_sel;
    logic [NBANK-1:0]     bank_open;
    logic [ADDRWIDTH-1:0] row_mem [NBANK];
    logic [BEATWIDTH-1:0] ccd_cnt;
    logic                 is_rd, is_wr, is_rdwr, tgt_open;
    logic                 trcd_busy;
    burst_t               cmd_pay;

    assign bank_sel = {bus.bg, bus.ba};

    // Command decode; anything not selected or clock-disabled is a deselect.
    always_comb begin
        dec_valid = 1'b0;
        dec_rfu   = 1'b0;
        dec_cmd   = CMD_NOP;
        if (bus.cke && !bus.cs_n) begin
            if (!bus.act_n) begin
                dec_valid = 1'b1;
                dec_cmd   = CMD_ACT;
            end else begin
                case (bus.A[ADDRWIDTH-1 -: 3])
                    3'b101:  begin dec_valid = 1'b1; dec_cmd = CMD_RD;  end
                    3'b100:  begin dec_valid = 1'b1; dec_cmd = CMD_WR;  end
                    3'b010:  begin
                        dec_valid = 1'b1;
                        dec_cmd   = bus.A[10] ? CMD_PREA : CMD_PRE;
                    end
                    3'b001:  begin dec_valid = 1'b1; dec_cmd = CMD_REF; end
                    3'b000:  begin dec_valid = 1'b1; dec_cmd = CMD_MRS; end
                    3'b011:  dec_rfu = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign is_rd    = dec_valid && (dec_cmd == CMD_RD);
    assign is_wr    = dec_valid && (dec_cmd == CMD_WR);
    assign is_rdwr  = is_rd || is_wr;
    assign tgt_open = bank_open[bank_sel];
    assign cmd_pay  = '{bank: bank_sel, row: row_mem[bank_sel],
                        col: bus.A[COLWIDTH-1:0]};

    always_ff @(posedge ck_t) begin
        if (!reset_n) begin
            bank_open <= '0;
            for (int i = 0; i < NBANK; i++) row_mem[i] <= '0;
        end else if (dec_valid) begin
            case (dec_cmd)
                CMD_ACT: begin
                    bank_open[bank_sel] <= 1'b1;
                    row_mem[bank_sel]   <= bus.A;
                end
                CMD_PRE:  bank_open[bank_sel] <= 1'b0;
                CMD_PREA: bank_open <= '0;
                default:  ;
            endcase
        end
    end

    // tCCD timer: any RD/WR (even to a closed bank) restarts the spacing window.
    always_ff @(posedge ck_t) begin
        if (!reset_n)           ccd_cnt <= '0;
        else if (is_rdwr)       ccd_cnt <= BEAT_LAST;
        else if (ccd_cnt != '0) ccd_cnt <= ccd_cnt - BEATWIDTH'(1);
    end

`ifdef TRCD_CHECK_EN
    localparam int TRCDW = (TRCD > 1) ? $clog2(TRCD) : 1;
    logic [TRCDW-1:0] trcd_cnt [NBANK];

    always_ff @(posedge ck_t) begin
        for (int i = 0; i < NBANK; i++) begin
            if (!reset_n)
                trcd_cnt[i] <= '0;
            else if (dec_valid && dec_cmd == CMD_ACT && bank_sel == BKWIDTH'(i))
                trcd_cnt[i] <= TRCDW'(TRCD - 1);
            else if (trcd_cnt[i] != '0)
                trcd_cnt[i] <= trcd_cnt[i] - TRCDW'(1);
        end
    end

    assign trcd_busy = (trcd_cnt[bank_sel] != '0);
`else
    assign trcd_busy = 1'b0;
`endif

    // Latency lines: a token entered at edge n reaches the last stage after
    // edge n+LAT-1, so the burst engine starts it at edge n+LAT.
    logic [CL-1:0]  rd_vld;
    logic [CWL-1:0] wr_vld;
    burst_t         rd_pay [CL];
    burst_t         wr_pay [CWL];

    always_ff @(posedge ck_t) begin
        if (!reset_n) begin
            rd_vld <= '0;
            for (int i = 0; i < CL; i++) rd_pay[i] <= '0;
        end else begin
            rd_vld[0] <= is_rd && tgt_open;
            rd_pay[0] <= cmd_pay;
            for (int i = 1; i < CL; i++) begin
                rd_vld[i] <= rd_vld[i-1];
                rd_pay[i] <= rd_pay[i-1];
            end
        end
    end

    always_ff @(posedge ck_t) begin
        if (!reset_n) begin
            wr_vld <= '0;
            for (int i = 0; i < CWL; i++) wr_pay[i] <= '0;
        end else begin
            wr_vld[0] <= is_wr && tgt_open;
            wr_pay[0] <= cmd_pay;
            for (int i = 1; i < CWL; i++) begin
                wr_vld[i] <= wr_vld[i-1];
                wr_pay[i] <= wr_pay[i-1];
            end
        end
    end

    // Burst engines. A newly emerging token always restarts the beat counter,
    // which gives seamless back-to-back bursts and truncates a tCCD-violating
    // older burst.
    logic                 rd_active, rd_start, rd_active_nxt;
    logic                 wr_active, wr_start, wr_active_nxt;
    logic [BEATWIDTH-1:0] rd_beat, wr_beat;
    burst_t               rd_cur, wr_cur;

    assign rd_start      = rd_vld[CL-1];
    assign wr_start      = wr_vld[CWL-1];
    assign rd_active_nxt = rd_start || (rd_active && rd_beat != BEAT_LAST);
    assign wr_active_nxt = wr_start || (wr_active && wr_beat != BEAT_LAST);

    always_ff @(posedge ck_t) begin
        if (!reset_n) begin
            rd_active <= 1'b0;
            rd_beat   <= '0;
            rd_cur    <= '0;
        end else begin
            rd_active <= rd_active_nxt;
            if (rd_start) begin
                rd_beat <= '0;
                rd_cur  <= rd_pay[CL-1];
            end else if (rd_active_nxt) begin
                rd_beat <= rd_beat + BEATWIDTH'(1);
            end
        end
    end

    always_ff @(posedge ck_t) begin
        if (!reset_n) begin
            wr_active <= 1'b0;
            wr_beat   <= '0;
            wr_cur    <= '0;
        end else begin
            wr_active <= wr_active_nxt;
            if (wr_start) begin
                wr_beat <= '0;
                wr_cur  <= wr_pay[CWL-1];
            end else if (wr_active_nxt) begin
                wr_beat <= wr_beat + BEATWIDTH'(1);
            end
        end
    end

    // Error arbitration: the lowest code wins when several fire together.
    // Overlap is judged on the next-cycle windows so the pulse lines up with
    // the cycle in which rd_en and wr_en are both high.
    logic       err_nxt;
    logic [2:0] code_nxt;

    always_comb begin
        err_nxt  = 1'b1;
        code_nxt = 3'd0;
        if (is_rdwr && !tgt_open)
            code_nxt = 3'd1;
        else if (dec_valid && dec_cmd == CMD_ACT && tgt_open)
            code_nxt = 3'd2;
        else if (is_rdwr && trcd_busy)
            code_nxt = 3'd3;
        else if (is_rdwr && ccd_cnt != '0)
            code_nxt = 3'd4;
        else if (rd_active_nxt && wr_active_nxt)
            code_nxt = 3'd5;
        else if (dec_rfu || (dec_valid && dec_cmd == CMD_REF && |bank_open))
            code_nxt = 3'd6;
        else
            err_nxt = 1'b0;
    end

    logic                 cmd_valid_q, err_q;
    logic [2:0]           cmd_q, err_code_q;
    logic [BKWIDTH-1:0]   cmd_bank_q;
    logic [ADDRWIDTH-1:0] cmd_row_q;
    logic [COLWIDTH-1:0]  cmd_col_q;

    always_ff @(posedge ck_t) begin
        if (!reset_n) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= 3'd0;
            cmd_bank_q  <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 3'd0;
        end else begin
            cmd_valid_q <= dec_valid;
            if (dec_valid) begin
                cmd_q      <= dec_cmd;
                cmd_bank_q <= bank_sel;
                cmd_row_q  <= bus.A;
                cmd_col_q  <= bus.A[COLWIDTH-1:0];
            end
            err_q <= err_nxt;
            if (err_nxt) err_code_q <= code_nxt;
        end
    end

    burst_t               burst_sel;
    logic [BEATWIDTH-1:0] beat_sel;

    assign burst_sel = wr_active ? wr_cur  : rd_cur;
    assign beat_sel  = wr_active ? wr_beat : rd_beat;

    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd        = cmd_q;
    assign bus.cmd_bank   = cmd_bank_q;
    assign bus.cmd_row    = cmd_row_q;
    assign bus.cmd_col    = cmd_col_q;
    assign bus.bank_open  = bank_open;
    assign bus.rd_en      = rd_active;
    assign bus.wr_en      = wr_active;
    assign bus.burst_bank = burst_sel.bank;
    assign bus.burst_row  = burst_sel.row;
    assign bus.burst_col  = burst_sel.col + (COLWIDTH'(beat_sel) << 1);
    assign bus.burst_beat = beat_sel;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;
endmodule

// File: tb/tb_ddr4_cmd_decoder.sv
// Bench for ddr4_cmd_decoder: a small bank/timing model pushes expected
// command reports and burst beats into queues when commands are driven; a
// negedge monitor pops and compares them as the decoder produces output and
// otherwise requires the outputs to be idle.
module tb_ddr4_cmd_decoder;
    localparam int CL   = 15;
    localparam int CWL  = 11;
    localparam int BL   = 8;
    localparam int TRCD = 15;

    logic ck_t    = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;

    always #5 ck_t = ~ck_t;
    always @(posedge ck_t) cyc <= cyc + 1;

    ddr4_cmd_decoder_if #(.BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17),
                          .COLWIDTH(10), .BL(BL)) bus ();

    ddr4_cmd_decoder #(.BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17), .COLWIDTH(10),
                       .BL(BL), .CL(CL), .CWL(CWL), .TRCD(TRCD)) dut (
        .ck_t    (ck_t),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int          cyc;
        bit          is_wr;
        logic [3:0]  bank;
        logic [16:0] row;
        logic [9:0]  col;
        logic [1:0]  beat;
    } beat_t;

    typedef struct {
        int         cyc;
        bit         vld;
        logic [2:0] cmd;
        logic [3:0] bank;
        bit         err;
        logic [2:0] code;
    } cmd_t;

    beat_t       bq[$];
    cmd_t        cq[$];
    beat_t       be;
    cmd_t        ce;
    int          n_chk  = 0;
    int          n_pass = 0;
    bit          mon_en = 0;
    bit          m_open [16];
    logic [16:0] m_row  [16];
    int          m_act  [16];
    int          m_last_rw;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(negedge ck_t);
            #1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 0;
            m_row[i]  = '0;
            m_act[i]  = -1000;
        end
        m_last_rw = -1000;
    endtask

    // Drive one command for one edge; evld=0 marks the RFU encoding.
    task automatic issue(input bit an, input logic [16:0] a, input logic [3:0] bk,
                         input logic [2:0] ecmd, input bit evld);
        int    n, code, lat;
        bit    isw;
        beat_t b;
        cmd_t  c;
        n    = cyc + 1;
        code = 0;
        if (!evld) begin
            code = 6;
        end else begin
            case (ecmd)
                3'd1: begin
                    if (m_open[bk]) code = 2;
                    m_open[bk] = 1;
                    m_row[bk]  = a;
                    m_act[bk]  = n;
                end
                3'd2, 3'd3: begin
                    if (!m_open[bk]) code = 1;
`ifdef TRCD_CHECK_EN
                    else if (n - m_act[bk] < TRCD) code = 3;
`endif
                    else if (n - m_last_rw < BL / 2) code = 4;
                    m_last_rw = n;
                    if (m_open[bk]) begin
                        isw = (ecmd == 3'd3);
                        lat = isw ? CWL : CL;
                        while (bq.size() != 0 && bq[$].is_wr == isw && bq[$].cyc >= n + lat)
                            void'(bq.pop_back());
                        for (int i = 0; i < BL / 2; i++) begin
                            b.cyc   = n + lat + i;
                            b.is_wr = isw;
                            b.bank  = bk;
                            b.row   = m_row[bk];
                            b.col   = a[9:0] + 10'(2 * i);
                            b.beat  = 2'(i);
                            bq.push_back(b);
                        end
                    end
                end
                3'd4: m_open[bk] = 0;
                3'd5: for (int i = 0; i < 16; i++) m_open[i] = 0;
                3'd6: for (int i = 0; i < 16; i++) if (m_open[i]) code = 6;
                default: ;
            endcase
        end
        c.cyc  = n;
        c.vld  = evld;
        c.cmd  = ecmd;
        c.bank = bk;
        c.err  = (code != 0);
        c.code = 3'(code);
        cq.push_back(c);
        bus.cs_n  = 1'b0;
        bus.act_n = an;
        bus.A     = a;
        bus.bg    = bk[3:2];
        bus.ba    = bk[1:0];
        tick(1);
        bus.cs_n  = 1'b1;
        bus.act_n = 1'b1;
    endtask

    always @(negedge ck_t) begin
        if (mon_en) begin
            if (cq.size() != 0 && cq[0].cyc == cyc) begin
                ce = cq.pop_front();
                chk("cmd_valid", bus.cmd_valid, ce.vld);
                if (ce.vld) begin
                    chk("cmd", bus.cmd, ce.cmd);
                    chk("cmd_bank", bus.cmd_bank, ce.bank);
                end
                chk("err", bus.err, ce.err);
                if (ce.err) chk("err_code", bus.err_code, ce.code);
            end else begin
                chk("idle_cmd_valid", bus.cmd_valid, 0);
                chk("idle_err", bus.err, 0);
            end
            if (bq.size() != 0 && bq[0].cyc == cyc) begin
                be = bq.pop_front();
                chk("rd_en", bus.rd_en, !be.is_wr);
                chk("wr_en", bus.wr_en, be.is_wr);
                chk("burst_bank", bus.burst_bank, be.bank);
                chk("burst_row", bus.burst_row, be.row);
                chk("burst_col", bus.burst_col, be.col);
                chk("burst_beat", bus.burst_beat, be.beat);
            end else begin
                chk("idle_rd_en", bus.rd_en, 0);
                chk("idle_wr_en", bus.wr_en, 0);
            end
        end
    end

    initial begin
        bus.cke   = 1'b0;
        bus.cs_n  = 1'b1;
        bus.act_n = 1'b1;
        bus.A     = '0;
        bus.bg    = '0;
        bus.ba    = '0;
        model_reset();
        tick(3);
        chk("rst_cmd_valid", bus.cmd_valid, 0);
        chk("rst_cmd", bus.cmd, 0);
        chk("rst_bank_open", bus.bank_open, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_err_code", bus.err_code, 0);
        reset_n = 1'b1;
        bus.cke = 1'b1;
        mon_en  = 1;

        // ACT bank 5 row 1
        issue(1'b0, 17'h00001, 4'd5, 3'd1, 1);
        chk("act_bank_open5", bus.bank_open[5], 1);
        chk("act_cmd_row", bus.cmd_row, 17'h00001);
        tick(30);

        // WR col 2: four write beats from CWL edges later
        issue(1'b1, 17'h10002, 4'd5, 3'd3, 1);
        tick(20);

        // RD pair at exactly BL/2 spacing: seamless, no error
        issue(1'b1, 17'h14002, 4'd5, 3'd2, 1);
        tick(3);
        issue(1'b1, 17'h14010, 4'd5, 3'd2, 1);
        tick(25);

        // RD pair 2 apart: tCCD error, second burst truncates the first
        issue(1'b1, 17'h14002, 4'd5, 3'd2, 1);
        tick(1);
        issue(1'b1, 17'h143FE, 4'd5, 3'd2, 1);
        tick(25);

        // RD to closed bank 0: code 1, no burst; code is held afterwards
        issue(1'b1, 17'h14002, 4'd0, 3'd2, 1);
        tick(3);
        chk("err_code_held", bus.err_code, 1);

        // RFU encoding, then REF while bank 5 is open
        issue(1'b1, 17'h0C000, 4'd0, 3'd0, 0);
        tick(2);
        issue(1'b1, 17'h04000, 4'd0, 3'd6, 1);
        tick(2);

        // Deselects (cs_n high, then cke low) must not open bank 0
        bus.cs_n  = 1'b1;
        bus.act_n = 1'b0;
        bus.A     = 17'h00003;
        bus.bg    = 2'd0;
        bus.ba    = 2'd0;
        tick(1);
        bus.cke  = 1'b0;
        bus.cs_n = 1'b0;
        tick(1);
        bus.cke   = 1'b1;
        bus.cs_n  = 1'b1;
        bus.act_n = 1'b1;
        tick(1);
        chk("desel_bank_open", bus.bank_open, 16'h0020);

        // PRE bank 5
        issue(1'b1, 17'h08000, 4'd5, 3'd4, 1);
        chk("pre_bank_open5", bus.bank_open[5], 0);
        tick(2);

        // ACT to an already open bank: code 2; then PREA closes everything
        issue(1'b0, 17'h00007, 4'd2, 3'd1, 1);
        tick(2);
        issue(1'b0, 17'h00009, 4'd2, 3'd1, 1);
        tick(2);
        issue(1'b1, 17'h08400, 4'd0, 3'd5, 1);
        chk("prea_bank_open", bus.bank_open, 0);
        tick(2);

        // ACT then WR 5 cycles later: tRCD (if enabled), burst still runs
        issue(1'b0, 17'h00055, 4'd3, 3'd1, 1);
        tick(4);
        issue(1'b1, 17'h10004, 4'd3, 3'd3, 1);
        tick(20);

        // MRS is reported only
        issue(1'b1, 17'h00000, 4'd0, 3'd7, 1);
        tick(2);

        // Reset in the middle of a read burst
        issue(1'b0, 17'h00001, 4'd5, 3'd1, 1);
        tick(20);
        issue(1'b1, 17'h14002, 4'd5, 3'd2, 1);
        tick(CL + 1);
        reset_n = 1'b0;
        mon_en  = 0;
        bq.delete();
        cq.delete();
        tick(1);
        chk("rst_mid_rd_en", bus.rd_en, 0);
        chk("rst_mid_bank_open", bus.bank_open, 0);
        reset_n = 1'b1;
        model_reset();
        mon_en = 1;
        tick(30);

        chk("beats_drained", bq.size(), 0);
        chk("cmds_drained", cq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ddr4_cmd_decoder.md
# ddr4_cmd_decoder

Device-side DDR4 command decoder for the emulated DIMM. It samples the host command/address pins on every rising `ck_t` edge and decodes them into typed commands. It tracks per-bank open/closed state and open row, and schedules read and write data-burst windows at CAS latency and CAS write latency. Its outputs drive the DIMM's bank arrays and emulation cache, and it flags protocol violations made by the host.

## Interface
Parameters:
- `BGWIDTH`, 2: bank-group address width
- `BAWIDTH`, 2: bank address width
- `ADDRWIDTH`, 17: row/command address width, A[16:0]
- `COLWIDTH`, 10: column width
- `BL`, 8: burst length; a burst occupies BL/2 ck_t cycles
- `CL`, 15: read latency in cycles
- `CWL`, 11: write latency in cycles
- `TRCD`, 15: minimum ACT-to-RD/WR spacing, same bank

Ports (one clock; reset is synchronous and active-low):
- `ck_t` in 1: clock, all logic on rising edge
- `reset_n` in 1: synchronous active-low reset
- `cke` in 1: clock enable; low means command sampled as deselect
- `cs_n` in 1: chip select, active-low
- `act_n` in 1: activate, active-low
- `A` in ADDRWIDTH: address; A16/A15/A14 = RAS_n/CAS_n/WE_n when act_n=1; A10 = AP; A12 = BC_n
- `bg` in BGWIDTH, `ba` in BAWIDTH: target bank
- `cmd_valid` out 1: decoded command present
- `cmd` out 3: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 MRS
- `cmd_bank` out BGWIDTH+BAWIDTH: {bg,ba}
- `cmd_row` out ADDRWIDTH, `cmd_col` out COLWIDTH
- `bank_open` out 2^(BGWIDTH+BAWIDTH): per-bank open flag
- `rd_en` out 1, `wr_en` out 1: burst beat active
- `burst_bank` out BGWIDTH+BAWIDTH, `burst_row` out ADDRWIDTH, `burst_col` out COLWIDTH: burst target
- `burst_beat` out log2(BL/2): beat index within the burst
- `err` out 1: one-cycle violation pulse
- `err_code` out 3: cause, held until the next `err`

## Operation
- Decode applies only when cke=1 and cs_n=0. Otherwise the sample is a deselect: no `cmd_valid`, no state change.
- act_n=0 decodes as ACT, with row = A and bank = {bg,ba}.
- act_n=1 decodes from {RAS_n,CAS_n,WE_n} = A[16:14]:
  - 111 NOP
  - 101 RD
  - 100 WR
  - 010 PRE, or PREA if A10=1
  - 001 REF
  - 000 MRS
  - 011 reserved (RFU)
- NOP and RFU do not raise `cmd_valid`. RFU raises err code 6.
- Bank state, indexed by {bg,ba}:
  - ACT sets the bank open and stores the row.
  - PRE clears the addressed bank; PREA clears all banks.
  - REF with any bank open raises err code 6; state is unchanged.
  - MRS is reported only.
- RD/WR to an open bank schedules a burst on the stored row, column = A[COLWIDTH-1:0].
- RD/WR to a closed bank raises err code 1; the command is reported but no burst is scheduled.
- ACT to an open bank raises err code 2; the new row is stored.
- A10 and A12 on RD/WR are ignored. Bursts are always BL with no auto-precharge.
- Burst scheduling:
  - Separate read and write delay lines, depth CL and CWL.
  - Each carries a start token plus bank/row/column.
  - When a token emerges, its burst runs BL/2 cycles with `burst_beat` counting 0..BL/2-1.
  - `burst_col` = start column + 2·beat, modulo 2^COLWIDTH.
- tCCD: a RD or WR issued fewer than BL/2 cycles after the previous RD or WR raises err code 4. The new burst is still scheduled; when it emerges it restarts the beat counter and truncates the older burst.
- If read and write windows overlap in a cycle: `rd_en` and `wr_en` are both high, `burst_*` follows the write, and err code 5 pulses.
- If several errors occur in one cycle, the lowest code wins.

## Timing
- Command sampled at edge n: `cmd_*`, `bank_open` and `err` update at edge n (registered, visible during cycle n+1).
- RD at edge n: `rd_en` high for edges n+CL through n+CL+BL/2-1.
- WR at edge n: `wr_en` high for edges n+CWL through n+CWL+BL/2-1.
- Back-to-back RD at exactly BL/2 spacing: seamless `rd_en` with no gap and no error.
- Reset (reset_n low at an edge):
  - All outputs go to 0 and all banks close.
  - Delay lines and beat counters are flushed, aborting any in-flight burst at that edge.
  - The first command after reset is sampled at the edge after reset_n returns high.

## Configuration
- `TRCD_CHECK_EN` defined:
  - A per-bank counter is loaded to TRCD-1 on ACT and decrements to 0.
  - RD/WR while the counter is nonzero raises err code 3. The burst is still scheduled.
- Undefined: no counters and code 3 is never produced.

## Test plan
- Reset, then ACT bg=1 ba=1 A=1 → `cmd`=1, `cmd_bank`=5, `bank_open[5]`=1; no `err`.
- ACT as above; after 30 cycles, WR with A=17'b1_0000_0000_0000_0010 → `wr_en` high for 4 cycles starting 11 edges later; `burst_row`=1; `burst_col`=2,4,6,8; `burst_beat`=0..3.
- RD with A=17'b1_0100_0000_0000_0010 to the same open bank → `rd_en` high 15 edges later for 4 cycles. A second RD 4 cycles after the first → continuous 8-cycle `rd_en`, no `err`.
- RD to closed bank 0 → `cmd`=2, `err`=1, `err_code`=1, `rd_en` never asserts. Then PRE with A=17'b0_1000_0000_0000_0000 on bank 5 → `bank_open[5]`=0.
- With `TRCD_CHECK_EN`: ACT then WR 5 cycles later → `err_code`=3 and the burst still occurs. Without the macro → no `err`.
- Pull reset_n low mid-read-burst → `rd_en`=0 and `bank_open`=0 at the next edge; no residual burst after release.
